uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller between the UART receiver and the system bus. Captures each completed byte from the receiver into a small FIFO and exposes status, data, control and timeout registers to the CPU. Flags overrun and receive-idle timeout, and drives a level interrupt. Replaces direct polling of the receiver's single `rx_data` register.

## Interface
- `FIFO_DEPTH`, default 8: FIFO entries; must be a power of two, 2..16.
- `TIMEOUT_DEFAULT`, default 16'd1000: reset value of the TIMEOUT register, in clk cycles.
- `clk` in 1: system clock; all logic rises on this edge.
- `reset` in 1: reset, asynchronous, active-low; asserting it clears all state immediately.
- `rx_end` in 1: one-cycle pulse from the receiver marking a valid byte on `rx_data`.
- `rx_data` in 8: received byte, valid while `rx_end` is high.
- `rx_busy` in 1: receiver mid-frame.
- `cs_` in 1: chip select, active-low.
- `as_` in 1: address strobe, active-low.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 2: register index; 0 STATUS, 1 DATA, 2 CTRL, 3 TIMEOUT.
- `wr_data` in 32: write data.
- `rd_data` out 32: read data. Reset 0.
- `rdy_` out 1: access-complete strobe, active-low. Reset 1.
- `irq` out 1: level interrupt. Reset 0.

## Operation
- **Access definition**: an access is any cycle with `cs_`=0 and `as_`=0. Every access completes; there is no wait state.
- **STATUS register (read)**:
  - [0] not_empty
  - [1] full
  - [2] overrun (sticky)
  - [3] timeout (sticky)
  - [4] `rx_busy`
  - [12:8] count (0..FIFO_DEPTH)
  - all other bits 0
- **STATUS register (write)**: writing 1 to bit 2 or bit 3 clears that flag. Writing 0 has no effect.
- **DATA register (read)**:
  - FIFO non-empty: returns {24'b0, head byte} and pops the FIFO.
  - FIFO empty: returns 0 and does not pop.
  - Writes are ignored.
- **CTRL register**, reset value 0x11:
  - [0] ie_data
  - [1] ie_overrun
  - [2] ie_timeout
  - [4] rx_en
  - [3] flush: write-only; writing 1 empties the FIFO and resets the timeout counter. Reads as 0.
- **TIMEOUT register**: [15:0] reload value. A value of 0 disables timeout detection.
- **Push**: occurs when `rx_end`=1 and rx_en=1. While rx_en=0, `rx_end` is ignored entirely and never sets overrun.
- **Full FIFO**:
  - Push while full and no pop in the same cycle: byte is dropped, overrun is set, FIFO contents are unchanged.
  - Push and pop in the same cycle while full: both succeed, count is unchanged, no overrun.
- **Simultaneous events**:
  - Push and pop in the same cycle at any other count: count is unchanged.
  - Flush in the same cycle as a push: flush wins, the byte is discarded, no overrun.
  - Flag set and W1C clear in the same cycle: set wins.
- **Pointers**: log2(FIFO_DEPTH)-bit read and write pointers that wrap modulo the depth. Count is a separate counter of width log2(FIFO_DEPTH)+1.
- **Timeout counter** (16 bit):
  - Reloads from TIMEOUT on any of: push, pop, flush, `rx_busy`=1, or FIFO empty.
  - Otherwise decrements by 1 per cycle while non-zero.
  - On the 1→0 transition it sets the timeout flag, exactly once per idle period, then holds at 0.
- **Interrupt**: `irq` is registered and equals (ie_data & not_empty) | (ie_overrun & overrun) | (ie_timeout & timeout).
- **Reset mid-operation**: FIFO empties, both flags clear, CTRL returns to 0x11, TIMEOUT returns to TIMEOUT_DEFAULT, and any access in flight completes with no `rdy_` pulse.

## Timing
- **Access timing**: an access sampled at edge N drives `rdy_`=0 and `rd_data` (reads) during cycle N+1, for exactly one cycle.
  - Outside that cycle, `rdy_`=1 and `rd_data`=0.
  - Writes also return `rd_data`=0.
- **Register effects**: register writes and DATA pops take effect at edge N. STATUS read at edge N+1 reflects them.
- **Read contents**: `rd_data` for a read carries the register values captured at edge N, before that access's own pop or clear.
- **Push to STATUS latency**: a push at edge N is visible in STATUS for an access sampled at edge N+1.
- **Push to DATA latency**: a DATA read sampled at edge N+1 returns the pushed byte if the FIFO was empty.
- **Interrupt latency**: `irq` follows the underlying flags by one cycle. The cause set at edge N shows on `irq` after edge N+1.
- **Back-to-back accesses**: consecutive-cycle accesses are legal. Each produces its own `rdy_` pulse one cycle later.

## Test plan
- **Reset values**: assert reset mid-access, then release it and read STATUS, CTRL, TIMEOUT -> 0x0, 0x11, TIMEOUT_DEFAULT. No `rdy_` pulse appears for the aborted access. `irq`=0.
- **FIFO order and interrupt**: push 0x55 and 0xA3, then read DATA twice -> 0x55 then 0xA3. STATUS count goes 2→1→0. With ie_data=1, `irq` rises 2 cycles after the first `rx_end` and falls 2 cycles after the final pop.
- **Overrun**: push 9 bytes 0x00..0x08 with depth 8 -> STATUS=0x0807 (count 8, full, not_empty, overrun). Reads return 0x00..0x07. Write 0x4 to STATUS -> overrun clears. Push together with a pop while full -> no overrun.
- **Timeout**: set TIMEOUT=20 and ie_timeout=1, push one byte with `rx_busy`=0 -> timeout flag sets on cycle 20 after the push and `irq` rises one cycle later. A new push on cycle 10 restarts the count. TIMEOUT=0 -> flag never sets.
- **Flush and rx_en**: flush coincident with `rx_end` -> count=0, overrun=0. With rx_en=0, 3 `rx_end` pulses -> count stays 0.
- **Empty read and W1C collision**: read DATA while empty -> 0, count stays 0. W1C of overrun in the same cycle as an overflowing push -> overrun remains 1.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// CPU-side register bus of the UART receive controller.
// Strobes and rdy_ are active-low; rd_data is zero outside the completion cycle.
interface uart_rx_ctrl_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: buffers received bytes in a FIFO and exposes
// STATUS/DATA/CTRL/TIMEOUT registers with overrun, idle-timeout and interrupt.
module uart_rx_ctrl #(
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'd1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_end,
  input  logic [7:0]   rx_data,
  input  logic         rx_busy,
  uart_rx_ctrl_if.slave bus,
  output logic         irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          timeout;
  logic          ie_data;
  logic          ie_overrun;
  logic          ie_timeout;
  logic          rx_en;
  logic [15:0]   tmo_reload;
  logic [15:0]   tmo_cnt;

  logic          access;
  logic          rd_acc;
  logic          wr_acc;
  logic          not_empty;
  logic          full;
  logic          pop;
  logic          flush;
  logic          push_req;
  logic          push_ok;
  logic          ovr_set;
  logic          ovr_clr;
  logic          tmo_clr;
  logic          tmo_load;
  logic          tmo_hit;
  logic [31:0]   status_w;
  logic [31:0]   rd_mux;
  logic          unused_wr;

  assign unused_wr = ^bus.wr_data[31:16];

  assign access    = !bus.cs_ && !bus.as_;
  assign rd_acc    = access && bus.rw;
  assign wr_acc    = access && !bus.rw;
  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_C);

  assign pop      = rd_acc && (bus.addr == 2'd1) && not_empty;
  assign flush    = wr_acc && (bus.addr == 2'd2) && bus.wr_data[3];
  assign ovr_clr  = wr_acc && (bus.addr == 2'd0) && bus.wr_data[2];
  assign tmo_clr  = wr_acc && (bus.addr == 2'd0) && bus.wr_data[3];
  assign push_req = rx_end && rx_en;

  // A full FIFO still accepts a byte when the same cycle frees a slot;
  // flush discards the incoming byte outright.
  assign push_ok = push_req && !flush && (!full || pop);
  assign ovr_set = push_req && !flush && full && !pop;

  assign tmo_load = push_req || pop || flush || rx_busy || !not_empty;
  assign tmo_hit  = !tmo_load && (tmo_cnt == 16'd1);

  always_comb begin
    status_w       = '0;
    status_w[12:8] = 5'(count);
    status_w[4:0]  = {rx_busy, timeout, overrun, full, not_empty};
  end

  always_comb begin
    rd_mux = '0;
    unique case (bus.addr)
      2'd0: rd_mux = status_w;
      2'd1: rd_mux = not_empty ? {24'h0, mem[rd_ptr]} : 32'h0;
      2'd2: rd_mux = {27'h0, rx_en, 1'b0, ie_timeout, ie_overrun, ie_data};
      2'd3: rd_mux = {16'h0, tmo_reload};
    endcase
  end

  // FIFO storage: data only, no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      ie_data    <= 1'b1;
      ie_overrun <= 1'b0;
      ie_timeout <= 1'b0;
      rx_en      <= 1'b1;
      tmo_reload <= TIMEOUT_DEFAULT;
      tmo_cnt    <= TIMEOUT_DEFAULT;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop)     rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop);
      end

      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
      if (tmo_hit)      timeout <= 1'b1;
      else if (tmo_clr) timeout <= 1'b0;

      if (wr_acc && (bus.addr == 2'd2)) begin
        ie_data    <= bus.wr_data[0];
        ie_overrun <= bus.wr_data[1];
        ie_timeout <= bus.wr_data[2];
        rx_en      <= bus.wr_data[4];
      end
      if (wr_acc && (bus.addr == 2'd3)) tmo_reload <= bus.wr_data[15:0];

      // Counter parks at zero after firing, so the flag sets once per idle period
      if (tmo_load)            tmo_cnt <= tmo_reload;
      else if (tmo_cnt != '0)  tmo_cnt <= tmo_cnt - 16'd1;
    end
  end

  // Completion stage: one-cycle rdy_ strobe with read data captured pre-update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rdy_    <= 1'b1;
      bus.rd_data <= '0;
      irq         <= 1'b0;
    end else begin
      bus.rdy_    <= !access;
      bus.rd_data <= rd_acc ? rd_mux : 32'h0;
      irq         <= (ie_data && not_empty) || (ie_overrun && overrun) ||
                     (ie_timeout && timeout);
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_rx_ctrl;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_end = 1'b0;
  logic [7:0] rx_data = 8'h0;
  logic       rx_busy = 1'b0;
  logic       irq;

  uart_rx_ctrl_if bus();

  uart_rx_ctrl #(.FIFO_DEPTH(D), .TIMEOUT_DEFAULT(16'd1000)) dut (
    .clk(clk), .reset(rst_n), .rx_end(rx_end), .rx_data(rx_data),
    .rx_busy(rx_busy), .bus(bus), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, flags, and an idle-cycle count for timeout
  logic [7:0]  mq[$];
  logic        m_ovr, m_tmo, m_ied, m_ieo, m_iet, m_rxen;
  logic [15:0] m_treg, m_armed;
  int          m_idle;
  logic [31:0] exp_rd;
  logic        exp_rdy, exp_irq;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_ovr = 0; m_tmo = 0; m_ied = 1; m_ieo = 0; m_iet = 0; m_rxen = 1;
      m_treg = 16'd1000; m_armed = 16'd1000; m_idle = 0;
      exp_rd = 0; exp_rdy = 1; exp_irq = 0;
    end else begin
      int cnt;
      logic acc, rd, wr, pop, flush, pushr, fire, ovr_set;
      logic [31:0] rv, wd;
      cnt = mq.size();
      acc = !bus.cs_ && !bus.as_;
      rd = acc && bus.rw;
      wr = acc && !bus.rw;
      wd = bus.wr_data;
      case (bus.addr)
        2'd0: rv = (32'(cnt) << 8) | (32'(rx_busy) << 4) | (32'(m_tmo) << 3) |
                   (32'(m_ovr) << 2) | (32'(cnt == D) << 1) | 32'(cnt != 0);
        2'd1: rv = (cnt > 0) ? {24'h0, mq[0]} : 32'h0;
        2'd2: rv = (32'(m_rxen) << 4) | (32'(m_iet) << 2) | (32'(m_ieo) << 1) | 32'(m_ied);
        default: rv = {16'h0, m_treg};
      endcase
      exp_rdy = !acc;
      exp_rd  = rd ? rv : 32'h0;
      exp_irq = (m_ied && cnt != 0) || (m_ieo && m_ovr) || (m_iet && m_tmo);

      pop   = rd && bus.addr == 2'd1 && cnt > 0;
      flush = wr && bus.addr == 2'd2 && wd[3];
      pushr = rx_end && m_rxen;

      fire = 0;
      if (pushr || pop || flush || rx_busy || cnt == 0) begin
        m_idle = 0;
        m_armed = m_treg;
      end else begin
        m_idle++;
        fire = (m_armed != 0) && (m_idle == int'(m_armed));
      end

      ovr_set = 0;
      if (flush) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (pushr) begin
          if (cnt < D || pop) mq.push_back(rx_data);
          else ovr_set = 1;
        end
      end
      m_ovr = (m_ovr && !(wr && bus.addr == 2'd0 && wd[2])) || ovr_set;
      m_tmo = (m_tmo && !(wr && bus.addr == 2'd0 && wd[3])) || fire;
      if (wr && bus.addr == 2'd2) begin
        m_ied = wd[0]; m_ieo = wd[1]; m_iet = wd[2]; m_rxen = wd[4];
      end
      if (wr && bus.addr == 2'd3) m_treg = wd[15:0];
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rdy_", 32'(bus.rdy_), 32'(exp_rdy));
      chk("rd_data", bus.rd_data, exp_rd);
      chk("irq", 32'(irq), 32'(exp_irq));
    end
  end

  task automatic idle_bus();
    bus.cs_ = 1; bus.as_ = 1; bus.rw = 1; bus.addr = 0; bus.wr_data = 0;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs_ = 0; bus.as_ = 0; bus.rw = 0; bus.addr = a; bus.wr_data = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs_ = 0; bus.as_ = 0; bus.rw = 1; bus.addr = a; bus.wr_data = 0;
    @(negedge clk);
    d = bus.rd_data;
    idle_bus();
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    rx_end = 1; rx_data = b;
    @(negedge clk);
    rx_end = 0;
  endtask

  task automatic clean(input logic [31:0] ctrl);
    bus_wr(2'd2, ctrl | 32'h8);
    bus_wr(2'd0, 32'hC);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, wd;
    int p_push, p_acc, p_busy;
    idle_bus();
    repeat (3) @(negedge clk);
    rst_n = 1;
    cmp_en = 1;

    // Reset values, with reset landing on an access in flight
    bus_wr(2'd3, 32'd5);
    push(8'h42);
    @(negedge clk);
    bus.cs_ = 0; bus.as_ = 0; bus.rw = 1; bus.addr = 2'd0;
    @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("abort_rdy", 32'(bus.rdy_), 32'h1);
    idle_bus();
    @(negedge clk);
    rst_n = 1;
    bus_rd(2'd0, d); chk("rst_status", d, 32'h0);
    bus_rd(2'd2, d); chk("rst_ctrl", d, 32'h11);
    bus_rd(2'd3, d); chk("rst_timeout", d, 32'd1000);
    chk("rst_irq", 32'(irq), 32'h0);

    // FIFO order and data interrupt latency
    @(negedge clk); rx_end = 1; rx_data = 8'h55;
    @(negedge clk); rx_data = 8'hA3; chk("irq_t1", 32'(irq), 32'h0);
    @(negedge clk); rx_end = 0;      chk("irq_t2", 32'(irq), 32'h1);
    bus_rd(2'd0, d); chk("st_cnt2", d, 32'h201);
    bus_rd(2'd1, d); chk("data_55", d, 32'h55);
    bus_rd(2'd0, d); chk("st_cnt1", d, 32'h101);
    bus_rd(2'd1, d); chk("data_a3", d, 32'hA3);
    bus_rd(2'd0, d); chk("st_cnt0", d, 32'h0);
    @(negedge clk); chk("irq_fall", 32'(irq), 32'h0);

    // Overrun
    for (int i = 0; i < 9; i++) push(8'(i));
    bus_rd(2'd0, d); chk("st_overrun", d, 32'h807);
    for (int i = 0; i < 8; i++) begin
      bus_rd(2'd1, d); chk("ovr_data", d, 32'(i));
    end
    bus_wr(2'd0, 32'h4);
    bus_rd(2'd0, d); chk("ovr_w1c", d, 32'h0);
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    @(negedge clk);
    rx_end = 1; rx_data = 8'h18;
    bus.cs_ = 0; bus.as_ = 0; bus.rw = 1; bus.addr = 2'd1;
    @(negedge clk);
    rx_end = 0; d = bus.rd_data; idle_bus();
    chk("full_pushpop_data", d, 32'h10);
    bus_rd(2'd0, d); chk("full_pushpop_st", d, 32'h803);
    bus_rd(2'd1, d); chk("full_pushpop_next", d, 32'h11);

    // Timeout
    bus_wr(2'd3, 32'd20);
    clean(32'h14);
    @(negedge clk); rx_end = 1; rx_data = 8'h77;
    @(negedge clk); rx_end = 0;
    repeat (19) @(negedge clk);
    @(negedge clk); chk("tmo_irq_before", 32'(irq), 32'h0);
    @(negedge clk); chk("tmo_irq_rise", 32'(irq), 32'h1);
    bus_rd(2'd0, d); chk("tmo_status", d, 32'h109);
    clean(32'h14);
    @(negedge clk); rx_end = 1; rx_data = 8'h78;
    @(negedge clk); rx_end = 0;
    repeat (8) @(negedge clk);
    @(negedge clk); rx_end = 1; rx_data = 8'h79;
    @(negedge clk); rx_end = 0;
    repeat (10) @(negedge clk);
    @(negedge clk); chk("tmo_restart_t22", 32'(irq), 32'h0);
    repeat (9) @(negedge clk);
    chk("tmo_restart_t31", 32'(irq), 32'h0);
    @(negedge clk); chk("tmo_restart_t32", 32'(irq), 32'h1);
    bus_wr(2'd3, 32'd0);
    clean(32'h14);
    push(8'h7A);
    repeat (100) @(negedge clk);
    chk("tmo_off_irq", 32'(irq), 32'h0);
    bus_rd(2'd0, d); chk("tmo_off_status", d, 32'h101);

    // Flush with coincident push; rx_en gating
    clean(32'h10);
    for (int i = 0; i < 3; i++) push(8'hC0);
    @(negedge clk);
    rx_end = 1; rx_data = 8'hEE;
    bus.cs_ = 0; bus.as_ = 0; bus.rw = 0; bus.addr = 2'd2; bus.wr_data = 32'h18;
    @(negedge clk);
    rx_end = 0; idle_bus();
    bus_rd(2'd0, d); chk("flush_push", d, 32'h0);
    bus_wr(2'd2, 32'h01);
    for (int i = 0; i < 3; i++) push(8'hD0);
    bus_rd(2'd0, d); chk("rx_dis", d, 32'h0);
    bus_rd(2'd2, d); chk("ctrl_rb", d, 32'h1);

    // Empty read, W1C collision with overflowing push
    bus_wr(2'd2, 32'h11);
    bus_rd(2'd1, d); chk("empty_read", d, 32'h0);
    bus_rd(2'd0, d); chk("empty_status", d, 32'h0);
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    @(negedge clk);
    rx_end = 1; rx_data = 8'h99;
    bus.cs_ = 0; bus.as_ = 0; bus.rw = 0; bus.addr = 2'd0; bus.wr_data = 32'h4;
    @(negedge clk);
    rx_end = 0; idle_bus();
    bus_rd(2'd0, d); chk("w1c_collide", d, 32'h807);

    // Randomized traffic alternating busy and quiet segments
    bus_wr(2'd3, 32'd12);
    clean(32'h17);
    for (int seg = 0; seg < 10; seg++) begin
      p_push = (seg % 2 == 1) ? 2 : 35;
      p_acc  = (seg % 2 == 1) ? 3 : 30;
      p_busy = (seg % 2 == 1) ? 1 : 10;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        rx_end  = ($urandom_range(0, 99) < p_push);
        rx_data = 8'($urandom);
        rx_busy = ($urandom_range(0, 99) < p_busy);
        if ($urandom_range(0, 99) < p_acc) begin
          bus.cs_ = 0; bus.as_ = 0;
          bus.rw = 1'($urandom);
          bus.addr = 2'($urandom);
          wd = $urandom;
          if (bus.addr == 2'd2) begin
            wd[4] = ($urandom_range(0, 4) != 0);
            wd[3] = ($urandom_range(0, 7) == 0);
          end
          if (bus.addr == 2'd3) wd[15:0] = 16'($urandom_range(0, 30));
          bus.wr_data = wd;
        end else begin
          bus.cs_ = 1'($urandom);
          bus.as_ = ~bus.cs_;
          bus.rw = 1'($urandom);
          bus.addr = 2'($urandom);
          bus.wr_data = $urandom;
        end
      end
    end
    @(negedge clk);
    rx_end = 0; rx_busy = 0; idle_bus();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
